// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - shared constants, types and helpers for the PS/2 keyboard event queue
package kb_pkg;
   localparam logic [31:0] KB_DATA_ADDR = 32'hFFFF0000;
   localparam logic [31:0] KB_STAT_ADDR = 32'hFFFF0004;
   localparam logic [7:0]  SC_EXT       = 8'hE0;
   localparam logic [7:0]  SC_BRK       = 8'hF0;

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } kb_event_t;

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {D_IDLE, D_E0, D_F0, D_E0F0} dec_state_t;

   // PS/2 uses odd parity over data+parity, and the stop bit must be high.
   function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
      return (^{par, data}) && stop;
   endfunction
endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 line synchronizer, falling-edge detector, frame receiver and timeout
module ps2_rx
   import kb_pkg::*;
#(
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic       o_byte_valid,
   output logic [7:0] o_byte,
   output logic       o_frame_err
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

   logic [1:0] r_clk_sync;
   logic [1:0] r_data_sync;
   logic       r_clk_prev;
   rx_state_t  r_state;
   rx_state_t  w_state_next;
   logic [2:0] r_bit_idx;
   logic [7:0] r_shift;
   logic       r_par;
   logic [TW-1:0] r_timer;
   logic       w_fall;
   logic       w_data;
   logic       w_timeout;
   logic       w_done;
   logic       w_err;

   assign w_fall    = r_clk_prev & ~r_clk_sync[1];
   assign w_data    = r_data_sync[1];
   assign w_timeout = (r_state != RX_IDLE) && !w_fall && (r_timer == TIMER_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_sync  <= 2'b11;
         r_data_sync <= 2'b11;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
         r_data_sync <= {r_data_sync[0], i_ps2_data};
         r_clk_prev  <= r_clk_sync[1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= RX_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_done       = 1'b0;
      w_err        = 1'b0;
      case (r_state)
         RX_IDLE: if (w_fall && !w_data) w_state_next = RX_DATA;
         RX_DATA: if (w_fall && r_bit_idx == 3'd7) w_state_next = RX_PAR;
         RX_PAR:  if (w_fall) w_state_next = RX_STOP;
         RX_STOP: begin
            if (w_fall) begin
               w_state_next = RX_IDLE;
               if (frame_ok(r_shift, r_par, w_data)) w_done = 1'b1;
               else                                  w_err  = 1'b1;
            end
         end
         default: w_state_next = RX_IDLE;
      endcase
      if (w_timeout) begin
         w_state_next = RX_IDLE;
         w_err        = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_par        <= 1'b0;
         r_timer      <= '0;
         o_byte_valid <= 1'b0;
         o_byte       <= '0;
         o_frame_err  <= 1'b0;
      end else begin
         o_byte_valid <= w_done;
         o_frame_err  <= w_err;
         if (w_done) o_byte <= r_shift;
         // Timer measures idle time since the most recent falling edge.
         if (r_state == RX_IDLE || w_fall || w_timeout) r_timer <= '0;
         else                                           r_timer <= r_timer + TW'(1);
         if (w_fall) begin
            case (r_state)
               RX_IDLE: r_bit_idx <= '0;
               RX_DATA: begin
                  r_shift   <= {w_data, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
               end
               RX_PAR:  r_par <= w_data;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: rtl/kb_event_queue.sv
// rtl/kb_event_queue.sv - PS/2 keyboard controller: prefix decoder, event FIFO and bus registers
module kb_event_queue
   import kb_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   input  logic        MemRead,
   input  logic [31:0] Address,
   output logic [31:0] DataOut,
   output logic [7:0]  leds
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic       w_rx_valid;
   logic [7:0] w_rx_byte;
   logic       w_rx_err;
   dec_state_t r_dec;
   dec_state_t w_dec_next;
   logic       w_emit;
   kb_event_t  w_event;
   kb_event_t  r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [7:0] r_count;
   logic       r_ovf;
   logic       r_ferr;
   logic       w_rd_data;
   logic       w_rd_stat;
   logic       w_full;
   logic       w_not_empty;
   logic       w_pop;
   logic       w_push;
   logic       w_ovf_set;

   ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .clk          (clk),
      .reset        (reset),
      .i_ps2_clk    (ps2_clk),
      .i_ps2_data   (ps2_data),
      .o_byte_valid (w_rx_valid),
      .o_byte       (w_rx_byte),
      .o_frame_err  (w_rx_err)
   );

   always_ff @(posedge clk) begin
      if (reset) r_dec <= D_IDLE;
      else       r_dec <= w_dec_next;
   end

   always_comb begin
      w_dec_next = r_dec;
      w_emit     = 1'b0;
      w_event    = '0;
      if (w_rx_err) begin
         w_dec_next = D_IDLE;
      end else if (w_rx_valid) begin
         if (w_rx_byte == SC_EXT) begin
            if (r_dec == D_IDLE) w_dec_next = D_E0;
         end else if (w_rx_byte == SC_BRK) begin
            if (r_dec == D_IDLE)    w_dec_next = D_F0;
            else if (r_dec == D_E0) w_dec_next = D_E0F0;
         end else begin
            w_emit       = 1'b1;
            w_event.code = w_rx_byte;
            w_event.ext  = (r_dec == D_E0) || (r_dec == D_E0F0);
            w_event.brk  = (r_dec == D_F0) || (r_dec == D_E0F0);
            w_dec_next   = D_IDLE;
         end
      end
   end

   assign w_rd_data   = MemRead && (Address == KB_DATA_ADDR);
   assign w_rd_stat   = MemRead && (Address == KB_STAT_ADDR);
   assign w_not_empty = (r_count != 8'd0);
   assign w_full      = (r_count == 8'(FIFO_DEPTH));
   assign w_pop       = w_rd_data && w_not_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_push      = w_emit && (!w_full || w_pop);
   assign w_ovf_set   = w_emit && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_event;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_ferr   <= 1'b0;
         leds     <= '0;
         DataOut  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            leds     <= w_event.code;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + 8'd1;
         else if (w_pop && !w_push) r_count <= r_count - 8'd1;
         r_ovf  <= w_ovf_set | (r_ovf & ~w_rd_stat);
         r_ferr <= w_rx_err  | (r_ferr & ~w_rd_stat);
         if (w_rd_data)
            DataOut <= w_pop ? {21'b0, 1'b1, r_mem[r_rd_ptr]} : 32'd0;
         else if (w_rd_stat)
            DataOut <= {16'b0, r_count, 5'b0, r_ferr, r_ovf, w_not_empty};
         else
            DataOut <= 32'd0;
      end
   end
endmodule

// File: tb/tb_kb_event_queue.sv
// tb/tb_kb_event_queue.sv - directed self-checking bench for kb_event_queue
module tb_kb_event_queue;
   import kb_pkg::*;

   localparam int DEPTH = 8;
   localparam int TMO   = 200;
   localparam int HALF  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        MemRead = 1'b0;
   logic [31:0] Address = '0;
   wire  [31:0] DataOut;
   wire  [7:0]  leds;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   kb_event_queue #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .MemRead  (MemRead),
      .Address  (Address),
      .DataOut  (DataOut),
      .leds     (leds)
   );

   task automatic read_reg(input logic [31:0] addr, output logic [31:0] val);
      @(negedge clk);
      MemRead = 1'b1;
      Address = addr;
      @(negedge clk);
      MemRead = 1'b0;
      Address = '0;
      val = DataOut;
   endtask

   task automatic ps2_bit(input logic b, input logic rd_on_fall, output logic [31:0] rd_val);
      rd_val = '0;
      @(negedge clk);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (rd_on_fall) begin
         repeat (3) @(negedge clk);
         MemRead = 1'b1;
         Address = KB_DATA_ADDR;
         @(negedge clk);
         MemRead = 1'b0;
         Address = '0;
         rd_val = DataOut;
         repeat (HALF - 4) @(negedge clk);
      end else begin
         repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                             input logic rd_on_stop, output logic [31:0] rd_val);
      logic [31:0] dummy;
      logic par;
      par = (~^b) ^ bad_par;
      ps2_bit(1'b0, 1'b0, dummy);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, dummy);
      ps2_bit(par, 1'b0, dummy);
      ps2_bit(~bad_stop, rd_on_stop, rd_val);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      logic [31:0] dummy;
      send_frame(b, 1'b0, 1'b0, 1'b0, dummy);
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (DataOut !== 32'd0) begin
         $display("FAIL reset_dataout: got %h want %h", DataOut, 32'd0); miscompares++;
      end
      vectors++;
      if (leds !== 8'd0) begin
         $display("FAIL reset_leds: got %h want %h", leds, 8'd0); miscompares++;
      end
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'd0) begin
         $display("FAIL reset_status: got %h want %h", v, 32'd0); miscompares++;
      end
   endtask

   task automatic test_single_make();
      logic [31:0] v;
      send(8'h1C);
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'h0000_0101) begin
         $display("FAIL single_status: got %h want %h", v, 32'h0000_0101); miscompares++;
      end
      read_reg(KB_DATA_ADDR, v);
      vectors++;
      if (v !== 32'h0000_041C) begin
         $display("FAIL single_data: got %h want %h", v, 32'h0000_041C); miscompares++;
      end
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'd0) begin
         $display("FAIL single_status_after: got %h want %h", v, 32'd0); miscompares++;
      end
      vectors++;
      if (leds !== 8'h1C) begin
         $display("FAIL single_leds: got %h want %h", leds, 8'h1C); miscompares++;
      end
      read_reg(KB_DATA_ADDR, v);
      vectors++;
      if (v !== 32'd0) begin
         $display("FAIL empty_data: got %h want %h", v, 32'd0); miscompares++;
      end
   endtask

   task automatic test_prefixes();
      logic [31:0] v;
      logic [31:0] exp [3];
      exp[0] = 32'h0000_061C;
      exp[1] = 32'h0000_0575;
      exp[2] = 32'h0000_0775;
      send(8'hF0); send(8'h1C);
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      for (int i = 0; i < 3; i++) begin
         read_reg(KB_DATA_ADDR, v);
         vectors++;
         if (v !== exp[i]) begin
            $display("FAIL prefix_data%0d: got %h want %h", i, v, exp[i]); miscompares++;
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] v;
      logic [31:0] exp;
      for (int i = 0; i < 9; i++) send(8'h16 + 8'(i));
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'h0000_0803) begin
         $display("FAIL ovf_status: got %h want %h", v, 32'h0000_0803); miscompares++;
      end
      vectors++;
      if (leds !== 8'h1D) begin
         $display("FAIL ovf_leds: got %h want %h", leds, 8'h1D); miscompares++;
      end
      for (int i = 0; i < 8; i++) begin
         exp = 32'h0000_0416 + 32'(i);
         read_reg(KB_DATA_ADDR, v);
         vectors++;
         if (v !== exp) begin
            $display("FAIL ovf_data%0d: got %h want %h", i, v, exp); miscompares++;
         end
      end
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'd0) begin
         $display("FAIL ovf_status_cleared: got %h want %h", v, 32'd0); miscompares++;
      end
   endtask

   task automatic test_frame_errors();
      logic [31:0] v;
      logic [31:0] dummy;
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0, dummy);
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'h0000_0004) begin
         $display("FAIL bad_parity_status: got %h want %h", v, 32'h0000_0004); miscompares++;
      end
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0, dummy);
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'h0000_0004) begin
         $display("FAIL bad_stop_status: got %h want %h", v, 32'h0000_0004); miscompares++;
      end
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'd0) begin
         $display("FAIL ferr_cleared: got %h want %h", v, 32'd0); miscompares++;
      end
   endtask

   task automatic test_timeout();
      logic [31:0] v;
      logic [31:0] dummy;
      ps2_bit(1'b0, 1'b0, dummy);
      ps2_bit(1'b1, 1'b0, dummy);
      ps2_bit(1'b0, 1'b0, dummy);
      ps2_bit(1'b1, 1'b0, dummy);
      ps2_bit(1'b0, 1'b0, dummy);
      ps2_data = 1'b1;
      repeat (50) @(negedge clk);
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'd0) begin
         $display("FAIL timeout_early: got %h want %h", v, 32'd0); miscompares++;
      end
      repeat (TMO) @(negedge clk);
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'h0000_0004) begin
         $display("FAIL timeout_status: got %h want %h", v, 32'h0000_0004); miscompares++;
      end
      send(8'h2A);
      read_reg(KB_DATA_ADDR, v);
      vectors++;
      if (v !== 32'h0000_042A) begin
         $display("FAIL timeout_recover: got %h want %h", v, 32'h0000_042A); miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      logic [31:0] rd;
      send(8'h32);
      send_frame(8'h33, 1'b0, 1'b0, 1'b1, rd);
      vectors++;
      if (rd !== 32'h0000_0432) begin
         $display("FAIL b2b_old_entry: got %h want %h", rd, 32'h0000_0432); miscompares++;
      end
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'h0000_0101) begin
         $display("FAIL b2b_status: got %h want %h", v, 32'h0000_0101); miscompares++;
      end
      read_reg(KB_DATA_ADDR, v);
      vectors++;
      if (v !== 32'h0000_0433) begin
         $display("FAIL b2b_new_entry: got %h want %h", v, 32'h0000_0433); miscompares++;
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] v;
      logic [31:0] dummy;
      send(8'h44);
      ps2_bit(1'b0, 1'b0, dummy);
      ps2_bit(1'b1, 1'b0, dummy);
      ps2_bit(1'b1, 1'b0, dummy);
      ps2_bit(1'b0, 1'b0, dummy);
      ps2_data = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (leds !== 8'd0) begin
         $display("FAIL midreset_leds: got %h want %h", leds, 8'd0); miscompares++;
      end
      vectors++;
      if (DataOut !== 32'd0) begin
         $display("FAIL midreset_dataout: got %h want %h", DataOut, 32'd0); miscompares++;
      end
      read_reg(KB_STAT_ADDR, v);
      vectors++;
      if (v !== 32'd0) begin
         $display("FAIL midreset_status: got %h want %h", v, 32'd0); miscompares++;
      end
      send(8'h4D);
      read_reg(KB_DATA_ADDR, v);
      vectors++;
      if (v !== 32'h0000_044D) begin
         $display("FAIL midreset_recover: got %h want %h", v, 32'h0000_044D); miscompares++;
      end
      vectors++;
      if (leds !== 8'h4D) begin
         $display("FAIL midreset_leds_after: got %h want %h", leds, 8'h4D); miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_single_make();
      test_prefixes();
      test_overflow();
      test_frame_errors();
      test_timeout();
      test_back_to_back();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/kb_event_queue.md
# kb_event_queue

Memory-mapped PS/2 keyboard controller for the RV32I system bus. It oversamples the keyboard's ps2_clk/ps2_data lines in the system clock domain and validates each 11-bit frame. Scan-code prefixes (E0 extended, F0 break) are folded into single key events, which are buffered in a FIFO. The processor reads events through a pop-on-read DATA register at 0xFFFF0000 and a STATUS register at 0xFFFF0004.

## Interface
- FIFO_DEPTH, 8: event FIFO entries; power of two, 2..128
- TIMEOUT_CYC, 50000: clk cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 50 MHz)
- clk  in  1  system clock; sole clock of the block
- reset  in  1  synchronous, active-high reset
- ps2_clk  in  1  keyboard clock, asynchronous
- ps2_data  in  1  keyboard data, asynchronous
- MemRead  in  1  bus read strobe
- Address  in  32  bus address
- DataOut  out  32  registered read data
- leds  out  8  code byte of the most recently queued event

## Operation
- Input sync: ps2_clk and ps2_data each pass through a 2-FF synchronizer. A falling edge is the synchronized ps2_clk going 1 to 0 between consecutive cycles. ps2_data is sampled in that same cycle.
- Receiver FSM states:
  - RX_IDLE: a falling edge with data 0 moves to RX_DATA (bit index 0). A falling edge with data 1 is ignored.
  - RX_DATA: 8 data bits arrive LSB first; after bit 7, move to RX_PAR.
  - RX_PAR: capture the parity bit, then move to RX_STOP.
  - RX_STOP: capture the stop bit. The byte is accepted only if the 9 bits (data + parity) have an odd number of ones and stop=1. Otherwise set frame_err. Return to RX_IDLE either way.
- Timeout: in any non-IDLE receiver state, a timer counts cycles since the last falling edge. At TIMEOUT_CYC, discard the partial frame, set frame_err, and return to RX_IDLE.
- Decoder FSM, advanced by each accepted byte. States are D_IDLE, D_E0, D_F0, D_E0F0.
  - 0xE0: D_IDLE→D_E0; from any other state, stay.
  - 0xF0: D_IDLE→D_F0, D_E0→D_E0F0; from any other state, stay.
  - Any other byte emits event {brk, ext, code} and returns to D_IDLE. ext=1 in D_E0 and D_E0F0; brk=1 in D_F0 and D_E0F0.
  - A frame error or timeout forces D_IDLE.
- Event FIFO:
  - Push on emit; pop on a DATA read when not empty.
  - Push while full drops the new event and sets overflow; leds is not updated.
  - Simultaneous push and pop (including when full) performs both; count is unchanged.
  - Pop while empty has no effect.
- Register map; decode is full 32-bit:
  - DATA 0xFFFF0000: {21'b0, valid, brk, ext, code[7:0]}. valid=1 only when the FIFO was non-empty; the read pops one entry. When empty, returns 0.
  - STATUS 0xFFFF0004: {16'b0, count[7:0], 5'b0, frame_err, overflow, not_empty}. Reading STATUS clears frame_err and overflow. The returned word shows their values before clearing. A set event in the same cycle wins, so the bit stays 1.
  - Any other address, or MemRead=0: DataOut=0 next cycle, no side effects.
- leds: updated to the code byte on every successful push.

## Timing
- Reset values:
  - DataOut=0, leds=0.
  - FIFO empty, count=0, overflow=0, frame_err=0.
  - Receiver in RX_IDLE, decoder in D_IDLE, timer=0; synchronizer flops=1.
- Reset mid-frame discards all state. Subsequent line activity is handled as fresh input: a stray 0 edge starts a frame that ends in error or timeout.
- PS/2 input latency: 2 sync cycles plus 1 edge-detect cycle from a pad edge to the sampled bit.
- An accepted final byte is pushed to the FIFO 1 cycle after the stop-bit edge. From the following cycle it is visible to a STATUS or DATA read.
- Read latency: 1 cycle. MemRead and Address are sampled at posedge N; DataOut is valid after posedge N+1.
- Each cycle with MemRead=1 at DATA is one pop. A read held for k cycles pops up to k entries.

## Structure
- Shared package kb_pkg:
  - KB_DATA_ADDR=32'hFFFF0000, KB_STAT_ADDR=32'hFFFF0004
  - SC_EXT=8'hE0, SC_BRK=8'hF0
  - typedef kb_event_t {brk, ext, code[7:0]}
  - rx_state_t and dec_state_t enums
- Sub-module ps2_rx: synchronizers, edge detect, receiver FSM, and timeout. Outputs byte_valid (1-cycle pulse), byte[7:0], frame_err pulse.
- The top level holds the decoder FSM, FIFO, register decode, and sticky bits.

## Test plan
- Frame 0x1C with good parity → STATUS=0x0000_0101 → DATA read returns 0x0000_041C; next STATUS=0, leds=0x1C.
- Bytes F0,1C then E0,75 then E0,F0,75 → three DATA reads return 0x61C, 0x575, 0x775.
- 9 make codes 0x16..0x1E with FIFO_DEPTH=8 and no reads → STATUS count=8, overflow=1, leds=0x1D. Eight reads return 0x416..0x41D. The second STATUS read shows overflow=0.
- Frame 0x1C with a wrong parity bit, or with stop=0 → no event; STATUS frame_err=1, not_empty=0.
- Start bit plus 4 data bits, then idle for TIMEOUT_CYC → frame_err=1. A following valid 0x2A frame yields 0x42A.
- DATA read asserted in the same cycle as a push, with 1 entry queued → old entry returned, count stays 1. Reset asserted mid-frame → all outputs 0; next valid frame decoded normally.
